// File: rtl/ir_receiver_sm.sv
// ir_receiver_sm -- car-side IR packet decoder.
// Measures burst and gap lengths in prescaled ticks and validates the
// start, car-select and four data bursts. A good packet updates COMMAND and
// pulses PACKET_VALID. A malformed packet pulses PACKET_ERROR and returns to idle.
// Optional feature: define IR_RX_ERR_COUNT_EN to build the saturating
// rejected-packet counter behind ERR_COUNT. Without it, ERR_COUNT is tied to 0.
module ir_receiver_sm #(
   parameter int TICK_MAX        = 2499,
   parameter int START_SIZE      = 88,
   parameter int CAR_SELECT_SIZE = 22,
   parameter int GAP_SIZE        = 40,
   parameter int ASSERT_SIZE     = 44,
   parameter int DEASSERT_SIZE   = 22,
   parameter int TOL             = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IR_IN,
   output logic [3:0] COMMAND,
   output logic       PACKET_VALID,
   output logic       PACKET_ERROR,
   output logic [7:0] ERR_COUNT
);

   localparam int PW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_MAX);

   localparam logic [7:0] RUN_SAT  = 8'hFF;
   localparam logic [7:0] START_LO = 8'(START_SIZE - TOL);
   localparam logic [7:0] START_HI = 8'(START_SIZE + TOL);
   localparam logic [7:0] CAR_LO   = 8'(CAR_SELECT_SIZE - TOL);
   localparam logic [7:0] CAR_HI   = 8'(CAR_SELECT_SIZE + TOL);
   localparam logic [7:0] GAP_LO   = 8'(GAP_SIZE - TOL);
   localparam logic [7:0] GAP_HI   = 8'(GAP_SIZE + TOL);
   localparam logic [7:0] GAP_TMO  = 8'(GAP_SIZE + TOL + 1);
   localparam logic [7:0] ASRT_LO  = 8'(ASSERT_SIZE - TOL);
   localparam logic [7:0] ASRT_HI  = 8'(ASSERT_SIZE + TOL);
   localparam logic [7:0] DASRT_LO = 8'(DEASSERT_SIZE - TOL);
   localparam logic [7:0] DASRT_HI = 8'(DEASSERT_SIZE + TOL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_GAP_CAR,
      S_CAR,
      S_GAP_BIT,
      S_BIT
   } state_t;

   // A saturated run (255) never matches any window.
   function automatic logic in_win(input logic [7:0] run,
                                   input logic [7:0] lo,
                                   input logic [7:0] hi);
      return (run != RUN_SAT) && (run >= lo) && (run <= hi);
   endfunction

   logic          sync1_q, sync2_q;
   logic [PW-1:0] presc_q, presc_d;
   logic          prev_q, prev_d;
   logic [7:0]    run_q, run_d;
   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    shift_q, shift_d;
   logic [3:0]    cmd_q, cmd_d;
   logic          valid_q, valid_d;
   logic          error_q, error_d;

   logic          tick, lvl, rise, fall;
   logic [7:0]    run_inc;

   assign tick    = (presc_q == PRESC_LAST);
   assign lvl     = sync2_q;
   assign rise    = ~prev_q & lvl;
   assign fall    = prev_q & ~lvl;
   assign run_inc = (run_q == RUN_SAT) ? run_q : run_q + 8'd1;

   // Next-state decode: run measurement and packet FSM, evaluated on ticks only.
   always_comb begin
      // NOTE: every _d gets a default before any branch so no latch is inferred.
      presc_d = tick ? '0 : presc_q + 1'b1;
      prev_d  = prev_q;
      run_d   = run_q;
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      cmd_d   = cmd_q;
      valid_d = 1'b0;
      error_d = 1'b0;

      if (tick) begin
         prev_d = lvl;
         run_d  = (lvl == prev_q) ? run_inc : 8'd1;

         unique case (state_q)
            S_IDLE: begin
               if (rise) state_d = S_START;
            end
            S_START: begin
               if (fall) begin
                  if (in_win(run_q, START_LO, START_HI)) state_d = S_GAP_CAR;
                  else error_d = 1'b1;
               end
            end
            S_GAP_CAR: begin
               if (rise) begin
                  if (in_win(run_q, GAP_LO, GAP_HI)) state_d = S_CAR;
                  else error_d = 1'b1;
               end else if (run_inc == GAP_TMO) begin
                  error_d = 1'b1;
               end
            end
            S_CAR: begin
               if (fall) begin
                  if (in_win(run_q, CAR_LO, CAR_HI)) begin
                     state_d = S_GAP_BIT;
                     idx_d   = 2'd0;
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            S_GAP_BIT: begin
               if (rise) begin
                  if (in_win(run_q, GAP_LO, GAP_HI)) state_d = S_BIT;
                  else error_d = 1'b1;
               end else if (run_inc == GAP_TMO) begin
                  error_d = 1'b1;
               end
            end
            S_BIT: begin
               if (fall) begin
                  // The first data burst is forward (COMMAND[3]), so bit idx
                  // lands in shift position 3-idx, which is ~idx for 2 bits.
                  if (in_win(run_q, ASRT_LO, ASRT_HI)) begin
                     shift_d[~idx_q] = 1'b1;
                  end else if (in_win(run_q, DASRT_LO, DASRT_HI)) begin
                     shift_d[~idx_q] = 1'b0;
                  end else begin
                     error_d = 1'b1;
                  end

                  if (!error_d) begin
                     if (idx_q == 2'd3) begin
                        cmd_d   = shift_d;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                     end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_GAP_BIT;
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (error_d) state_d = S_IDLE;
      end
   end

   // State, synchronizer and registered outputs.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         // The synchronizer and prev reset high, so a burst already present
         // at release looks like a level that started before reset, not a start.
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         presc_q <= '0;
         prev_q  <= 1'b1;
         run_q   <= 8'd0;
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         shift_q <= 4'd0;
         cmd_q   <= 4'd0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync1_q <= IR_IN;
         sync2_q <= sync1_q;
         presc_q <= presc_d;
         prev_q  <= prev_d;
         run_q   <= run_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         cmd_q   <= cmd_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign COMMAND      = cmd_q;
   assign PACKET_VALID = valid_q;
   assign PACKET_ERROR = error_q;

`ifdef IR_RX_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating count of rejected packets, stepping with the error pulse.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (error_d && tick && (err_cnt_q != RUN_SAT)) err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register, cleared only by reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) err_cnt_q <= 8'd0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign ERR_COUNT = err_cnt_q;
`else
   assign ERR_COUNT = 8'd0;
`endif

endmodule

// File: tb/tb_ir_receiver_sm.sv
// Directed bench for ir_receiver_sm, run with a short tick (4 CLK per tick).
// Each level is held for an exact multiple of the tick period, so the DUT
// counts exactly the requested number of ticks.
module tb_ir_receiver_sm;
   localparam int TM = 3;
   localparam int P  = TM + 1;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       IR_IN = 1'b0;
   logic [3:0] COMMAND;
   logic       PACKET_VALID;
   logic       PACKET_ERROR;
   logic [7:0] ERR_COUNT;

   ir_receiver_sm #(.TICK_MAX(TM)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .IR_IN        (IR_IN),
      .COMMAND      (COMMAND),
      .PACKET_VALID (PACKET_VALID),
      .PACKET_ERROR (PACKET_ERROR),
      .ERR_COUNT    (ERR_COUNT)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Pulse monitor: counts high cycles of each output.
   int valid_cnt = 0, error_cnt = 0, both_cnt = 0;
   int last_valid_cyc = 0, last_error_cyc = 0;
   always @(negedge CLK) begin
      if (PACKET_VALID) begin
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cyc;
      end
      if (PACKET_ERROR) begin
         error_cnt      <= error_cnt + 1;
         last_error_cyc <= cyc;
      end
      if (PACKET_VALID && PACKET_ERROR) both_cnt <= both_cnt + 1;
   end

   int checks = 0, failures = 0;
   int fall_cyc = 0;
   int exp_errs = 0;
   int v0, e0, lat;

   function automatic logic [7:0] exp_err_count();
`ifdef IR_RX_ERR_COUNT_EN
      return (exp_errs > 255) ? 8'd255 : 8'(exp_errs);
`else
      return 8'd0;
`endif
   endfunction

   task automatic hi(input int n);
      @(posedge CLK);
      #1 IR_IN = 1'b1;
      repeat (n * P - 1) @(posedge CLK);
   endtask

   task automatic lo(input int n);
      @(posedge CLK);
      #1 IR_IN = 1'b0;
      fall_cyc = cyc;
      repeat (n * P - 1) @(posedge CLK);
   endtask

   // Full packet: b3 is sent first (forward) and b0 last (right).
   task automatic pkt(input int st, input int car,
                      input int b3, input int b2, input int b1, input int b0);
      hi(st);  lo(40);
      hi(car); lo(40);
      hi(b3);  lo(40);
      hi(b2);  lo(40);
      hi(b1);  lo(40);
      hi(b0);  lo(50);
   endtask

   task automatic settle();
      @(negedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      IR_IN = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (COMMAND !== 4'd0) begin failures++; $display("FAIL reset_cmd got=%b exp=%b", COMMAND, 4'd0); end
      checks++; if (PACKET_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", PACKET_VALID); end
      checks++; if (PACKET_ERROR !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", PACKET_ERROR); end
      checks++; if (ERR_COUNT !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", ERR_COUNT); end
      @(posedge CLK);
      #1 RESET = 1'b0;
      lo(10);
   endtask

   task automatic test_nominal();
      v0 = valid_cnt; e0 = error_cnt;
      pkt(88, 22, 44, 22, 44, 22);
      settle();
      lat = last_valid_cyc - fall_cyc;
      checks++; if (COMMAND !== 4'b1010) begin failures++; $display("FAIL nominal_cmd got=%b exp=%b", COMMAND, 4'b1010); end
      checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL nominal_valid_pulses got=%0d exp=1", valid_cnt - v0); end
      checks++; if (error_cnt - e0 != 0) begin failures++; $display("FAIL nominal_error_pulses got=%0d exp=0", error_cnt - e0); end
      checks++; if (lat < 3 || lat > P + 2) begin failures++; $display("FAIL nominal_latency got=%0d exp=3..%0d", lat, P + 2); end
   endtask

   task automatic test_bad_start();
      v0 = valid_cnt; e0 = error_cnt;
      hi(60); lo(50);
      settle();
      exp_errs++;
      lat = last_error_cyc - fall_cyc;
      checks++; if (error_cnt - e0 != 1) begin failures++; $display("FAIL bad_start_error_pulses got=%0d exp=1", error_cnt - e0); end
      checks++; if (lat < 3 || lat > P + 2) begin failures++; $display("FAIL bad_start_latency got=%0d exp=3..%0d", lat, P + 2); end
      checks++; if (COMMAND !== 4'b1010) begin failures++; $display("FAIL bad_start_cmd_hold got=%b exp=%b", COMMAND, 4'b1010); end
      checks++; if (valid_cnt - v0 != 0) begin failures++; $display("FAIL bad_start_valid got=%0d exp=0", valid_cnt - v0); end
      v0 = valid_cnt; e0 = error_cnt;
      pkt(88, 22, 22, 44, 22, 44);
      settle();
      checks++; if (COMMAND !== 4'b0101) begin failures++; $display("FAIL recover_cmd got=%b exp=%b", COMMAND, 4'b0101); end
      checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL recover_valid got=%0d exp=1", valid_cnt - v0); end
      checks++; if (error_cnt - e0 != 0) begin failures++; $display("FAIL recover_error got=%0d exp=0", error_cnt - e0); end
   endtask

   task automatic test_gap_timeout();
      v0 = valid_cnt; e0 = error_cnt;
      hi(88); lo(40); hi(22); lo(60);
      settle();
      exp_errs++;
      lat = last_error_cyc - fall_cyc;
      checks++; if (error_cnt - e0 != 1) begin failures++; $display("FAIL gap_tmo_error_pulses got=%0d exp=1", error_cnt - e0); end
      checks++; if (lat < 44 * P + 3 || lat > 45 * P + 2) begin failures++; $display("FAIL gap_tmo_latency got=%0d exp=%0d..%0d", lat, 44 * P + 3, 45 * P + 2); end
      checks++; if (valid_cnt - v0 != 0) begin failures++; $display("FAIL gap_tmo_valid got=%0d exp=0", valid_cnt - v0); end
      checks++; if (COMMAND !== 4'b0101) begin failures++; $display("FAIL gap_tmo_cmd_hold got=%b exp=%b", COMMAND, 4'b0101); end
   endtask

   task automatic test_car_select();
      v0 = valid_cnt; e0 = error_cnt;
      hi(88); lo(40); hi(44); lo(50);
      settle();
      exp_errs++;
      checks++; if (error_cnt - e0 != 1) begin failures++; $display("FAIL car_error_pulses got=%0d exp=1", error_cnt - e0); end
      checks++; if (COMMAND !== 4'b0101) begin failures++; $display("FAIL car_cmd_hold got=%b exp=%b", COMMAND, 4'b0101); end
      checks++; if (ERR_COUNT !== exp_err_count()) begin failures++; $display("FAIL car_errcnt got=%0d exp=%0d", ERR_COUNT, exp_err_count()); end
   endtask

   task automatic test_boundary();
      v0 = valid_cnt; e0 = error_cnt;
      pkt(88, 22, 40, 26, 26, 40);
      settle();
      checks++; if (COMMAND !== 4'b1001) begin failures++; $display("FAIL bound_26_40_cmd got=%b exp=%b", COMMAND, 4'b1001); end
      checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL bound_26_40_valid got=%0d exp=1", valid_cnt - v0); end
      checks++; if (error_cnt - e0 != 0) begin failures++; $display("FAIL bound_26_40_error got=%0d exp=0", error_cnt - e0); end

      v0 = valid_cnt; e0 = error_cnt;
      hi(88); lo(40); hi(22); lo(40); hi(27); lo(50);
      settle();
      exp_errs++;
      checks++; if (error_cnt - e0 != 1) begin failures++; $display("FAIL bound_27_error got=%0d exp=1", error_cnt - e0); end
      checks++; if (COMMAND !== 4'b1001) begin failures++; $display("FAIL bound_27_cmd_hold got=%b exp=%b", COMMAND, 4'b1001); end

      v0 = valid_cnt; e0 = error_cnt;
      hi(88); lo(40); hi(22); lo(40); hi(39); lo(50);
      settle();
      exp_errs++;
      checks++; if (error_cnt - e0 != 1) begin failures++; $display("FAIL bound_39_error got=%0d exp=1", error_cnt - e0); end
      checks++; if (valid_cnt - v0 != 0) begin failures++; $display("FAIL bound_39_valid got=%0d exp=0", valid_cnt - v0); end

      v0 = valid_cnt; e0 = error_cnt;
      pkt(84, 26, 18, 48, 48, 18);
      settle();
      checks++; if (COMMAND !== 4'b0110) begin failures++; $display("FAIL bound_edges_cmd got=%b exp=%b", COMMAND, 4'b0110); end
      checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL bound_edges_valid got=%0d exp=1", valid_cnt - v0); end
      checks++; if (ERR_COUNT !== exp_err_count()) begin failures++; $display("FAIL bound_errcnt got=%0d exp=%0d", ERR_COUNT, exp_err_count()); end
   endtask

   task automatic test_reset_mid_packet();
      v0 = valid_cnt; e0 = error_cnt;
      hi(88); lo(40); hi(22); lo(40); hi(44); lo(20);
      @(posedge CLK);
      #1 RESET = 1'b1;
      exp_errs = 0;
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      checks++; if (COMMAND !== 4'd0) begin failures++; $display("FAIL midrst_cmd got=%b exp=%b", COMMAND, 4'd0); end
      checks++; if (PACKET_VALID !== 1'b0 || PACKET_ERROR !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%b%b exp=00", PACKET_VALID, PACKET_ERROR); end
      checks++; if (ERR_COUNT !== 8'd0) begin failures++; $display("FAIL midrst_errcnt got=%0d exp=0", ERR_COUNT); end
      @(posedge CLK);
      #1 RESET = 1'b0;
      lo(20);
      settle();
      checks++; if (valid_cnt - v0 != 0 || error_cnt - e0 != 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d/%0d exp=0/0", valid_cnt - v0, error_cnt - e0); end

      v0 = valid_cnt; e0 = error_cnt;
      pkt(88, 22, 44, 44, 44, 44);
      settle();
      checks++; if (COMMAND !== 4'b1111) begin failures++; $display("FAIL after_rst_cmd got=%b exp=%b", COMMAND, 4'b1111); end
      checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL after_rst_valid got=%0d exp=1", valid_cnt - v0); end
      checks++; if (error_cnt - e0 != 0) begin failures++; $display("FAIL after_rst_error got=%0d exp=0", error_cnt - e0); end
   endtask

   task automatic test_exclusive();
      checks++; if (both_cnt != 0) begin failures++; $display("FAIL valid_error_overlap got=%0d exp=0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_start();
      test_gap_timeout();
      test_car_select();
      test_boundary();
      test_reset_mid_packet();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
